// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset/exception vectors and the fetch FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [31:0] EXC_PC_DEFAULT   = 32'hbfc00380;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } if_state_t;

endpackage

// File: rtl/if_ctrl_if.sv
// SRAM-like instruction bus: one request/address phase, one data phase, one outstanding transfer.
interface if_ctrl_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/if_pc_reg.sv
// Fetch PC register with load enable; synchronous reset to the boot vector.
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (ld_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_q_o = pc_q;

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the one-outstanding instruction bus and hands
// instructions to decode. Optional misaligned-fetch detection under IF_CTRL_ADEL_CHECK_EN.
module if_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [31:0]       epc,
    input  logic              br_valid,
    input  logic [31:0]       br_target,
    if_ctrl_if.master         bus,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_adel
);

    if_state_t   state_q, state_d;
    logic        cancel_q, cancel_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] pc_q, pc_nxt;
    logic        pc_ld;
    logic        req;
    logic        redirect;
    logic [31:0] target;
`ifdef IF_CTRL_ADEL_CHECK_EN
    logic        out_adel_q, out_adel_d;
`endif

    assign redirect = exc_valid | eret_valid | br_valid;
    assign target   = exc_valid  ? EXC_PC :
                      eret_valid ? epc    : br_target;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .ld_i   (pc_ld),
        .pc_d_i (pc_nxt),
        .pc_q_o (pc_q)
    );

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
`ifdef IF_CTRL_ADEL_CHECK_EN
        out_adel_d = out_adel_q;
`endif
        pc_ld      = 1'b0;
        pc_nxt     = target;
        req        = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
`ifdef IF_CTRL_ADEL_CHECK_EN
                // Misaligned PC: report the fault as a delivered slot instead of fetching.
                if (pc_q[1:0] != 2'b00) begin
                    if (redirect) begin
                        pc_ld = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        out_inst_d = '0;
                        out_pc_d   = pc_q;
                        out_adel_d = 1'b1;
                    end
                end else
`endif
                begin
                    req = 1'b1;
                    if (bus.inst_addr_ok) begin
                        state_d = WAIT;
                        if (redirect) begin
                            pc_ld    = 1'b1;
                            cancel_d = 1'b1;
                        end
                    end else if (redirect) begin
                        pc_ld = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    if (cancel_q || redirect) begin
                        cancel_d = 1'b0;
                        pc_ld    = redirect;
                        state_d  = REQ;
                    end else begin
                        out_inst_d = bus.inst_rdata;
                        out_pc_d   = pc_q;
`ifdef IF_CTRL_ADEL_CHECK_EN
                        out_adel_d = 1'b0;
`endif
                        pc_ld      = 1'b1;
                        pc_nxt     = pc_q + 32'd4;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pc_ld    = 1'b1;
                    cancel_d = 1'b1;
                end
            end
            HOLD: begin
                // A redirect drops the held instruction even while decode stalls.
                if (redirect) begin
                    pc_ld   = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cancel_q   <= 1'b0;
            out_inst_q <= '0;
            out_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            cancel_q   <= cancel_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
        end
    end

`ifdef IF_CTRL_ADEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_adel_q <= 1'b0;
        end else begin
            out_adel_q <= out_adel_d;
        end
    end

    assign out_adel      = out_adel_q;
    assign bus.inst_addr = pc_q;
`else
    assign out_adel      = 1'b0;
    assign bus.inst_addr = {pc_q[31:2], 2'b00};
`endif

    assign bus.inst_req = req & ~rst;
    assign out_valid    = (state_q == HOLD) & ~rst;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;

endmodule

// File: tb/tb_if_ctrl.sv
// Scoreboard bench for if_ctrl: expected bus requests and deliveries are queued by the stimulus
// and popped by monitors; a behavioural bus slave answers requests with configurable latency.
module tb_if_ctrl;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } dlv_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    if_ctrl_if bus();

    if_ctrl #(
        .RESET_PC (32'hbfc00000),
        .EXC_PC   (32'hbfc00380)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .bus        (bus),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_adel   (out_adel)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_req[$];
    dlv_t        exp_out[$];
    int addr_lat = 0;
    int data_lat = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'hbfc00000) ? 32'h24010001 : (a ^ 32'h5a5a0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        dlv_t d;
        d.pc = pc;
        d.inst = inst;
        d.adel = adel;
        exp_out.push_back(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_deliver(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            tick();
            if (out_valid) break;
        end
        if (i == 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: out_valid timeout got 0 expected 1", name);
        end
    endtask

    // Returns in the first WAIT cycle after the request has been accepted.
    task automatic wait_accept(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (bus.inst_addr_ok) begin
                tick();
                break;
            end
            tick();
        end
        if (i == 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: addr_ok timeout got 0 expected 1", name);
        end
    endtask

    // Bus slave: addr_ok after addr_lat request cycles, data_ok data_lat cycles after acceptance.
    initial begin
        int sl_st;
        int acnt;
        int dcnt;
        logic [31:0] paddr;
        sl_st = 0;
        acnt = 0;
        dcnt = 0;
        paddr = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            if (sl_st == 1) begin
                sl_st = 2;
                dcnt = 0;
            end
            if (sl_st == 2) begin
                if (dcnt == data_lat) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata = mem(paddr);
                    sl_st = 0;
                end else begin
                    dcnt++;
                end
            end else if (bus.inst_req) begin
                if (acnt == addr_lat) begin
                    bus.inst_addr_ok = 1'b1;
                    paddr = bus.inst_addr;
                    sl_st = 1;
                    acnt = 0;
                end else begin
                    acnt++;
                end
            end else begin
                acnt = 0;
            end
        end
    end

    // Request monitor: every accepted request must match the next expected address.
    always @(negedge clk) begin
        if (bus.inst_req && bus.inst_addr_ok) begin
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h expected no request", bus.inst_addr);
            end else begin
                check("req_addr", bus.inst_addr, exp_req.pop_front());
            end
        end
    end

    // Delivery monitor: each rising out_valid is one delivered slot.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_out.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h inst %h expected no delivery", out_pc, out_inst);
            end else begin
                dlv_t d;
                d = exp_out.pop_front();
                check("out_pc", out_pc, d.pc);
                check("out_inst", out_inst, d.inst);
                check("out_adel", {31'd0, out_adel}, {31'd0, d.adel});
            end
        end
        prev_valid <= out_valid;
    end

    initial begin
        rst = 1'b1;
        stall = 1'b1;
        exc_valid = 1'b0;
        eret_valid = 1'b0;
        epc = '0;
        br_valid = 1'b0;
        br_target = '0;

        repeat (2) tick();
        check("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_adel", {31'd0, out_adel}, 32'd0);
        check("rst_out_pc", out_pc, 32'hbfc00000);
        check("rst_inst_addr", bus.inst_addr, 32'hbfc00000);

        // Boot fetch
        exp_req.push_back(32'hbfc00000);
        push_out(32'hbfc00000, 32'h24010001, 1'b0);
        rst = 1'b0;
        check("idle_no_req", {31'd0, bus.inst_req}, 32'd0);
        tick();
        check("first_req", {31'd0, bus.inst_req}, 32'd1);
        check("first_addr", bus.inst_addr, 32'hbfc00000);
        wait_deliver("boot");

        // Stall in HOLD for 4 cycles
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_inst", out_inst, 32'h24010001);
            check("stall_no_req", {31'd0, bus.inst_req}, 32'd0);
            tick();
        end
        exp_req.push_back(32'hbfc00004);
        push_out(32'hbfc00004, mem(32'hbfc00004), 1'b0);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        check("consume_req", {31'd0, bus.inst_req}, 32'd1);
        check("consume_valid_fall", {31'd0, out_valid}, 32'd0);
        wait_deliver("seq");

        // Branch while waiting for data: response discarded
        data_lat = 2;
        exp_req.push_back(32'hbfc00008);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        wait_accept("br_wait");
        br_valid = 1'b1;
        br_target = 32'h80001000;
        exp_req.push_back(32'h80001000);
        push_out(32'h80001000, mem(32'h80001000), 1'b0);
        tick();
        br_valid = 1'b0;
        check("br_wait_no_valid", {31'd0, out_valid}, 32'd0);
        wait_deliver("br_wait");
        data_lat = 0;

        // All redirect sources together, in HOLD under stall: exception wins
        exc_valid = 1'b1;
        eret_valid = 1'b1;
        epc = 32'h80000040;
        br_valid = 1'b1;
        br_target = 32'h80001000;
        exp_req.push_back(32'hbfc00380);
        push_out(32'hbfc00380, mem(32'hbfc00380), 1'b0);
        tick();
        exc_valid = 1'b0;
        eret_valid = 1'b0;
        br_valid = 1'b0;
        check("exc_valid_fall", {31'd0, out_valid}, 32'd0);
        check("exc_req", {31'd0, bus.inst_req}, 32'd1);
        check("exc_addr", bus.inst_addr, 32'hbfc00380);
        wait_deliver("exc");

        // ERET beats branch
        eret_valid = 1'b1;
        epc = 32'h80000040;
        br_valid = 1'b1;
        br_target = 32'h80001000;
        exp_req.push_back(32'h80000040);
        push_out(32'h80000040, mem(32'h80000040), 1'b0);
        tick();
        eret_valid = 1'b0;
        br_valid = 1'b0;
        check("eret_addr", bus.inst_addr, 32'h80000040);
        wait_deliver("eret");

        // Misaligned branch target
        br_valid = 1'b1;
        br_target = 32'h80000002;
`ifdef IF_CTRL_ADEL_CHECK_EN
        push_out(32'h80000002, 32'h0, 1'b1);
        tick();
        br_valid = 1'b0;
        check("adel_no_req", {31'd0, bus.inst_req}, 32'd0);
`else
        exp_req.push_back(32'h80000000);
        push_out(32'h80000002, mem(32'h80000000), 1'b0);
        tick();
        br_valid = 1'b0;
        check("misal_addr", bus.inst_addr, 32'h80000000);
`endif
        wait_deliver("misal");

        // Reset during WAIT with the late response arriving under reset
        data_lat = 3;
        br_valid = 1'b1;
        br_target = 32'h80002000;
        exp_req.push_back(32'h80002000);
        tick();
        br_valid = 1'b0;
        wait_accept("rst_wait");
        tick();
        rst = 1'b1;
        exp_req.push_back(32'hbfc00000);
        push_out(32'hbfc00000, 32'h24010001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_wait_no_valid", {31'd0, out_valid}, 32'd0);
            check("rst_wait_no_req", {31'd0, bus.inst_req}, 32'd0);
        end
        data_lat = 0;
        rst = 1'b0;
        wait_deliver("rst_refetch");

        repeat (3) tick();
        check("req_queue_empty", exp_req.size(), 32'd0);
        check("out_queue_empty", exp_out.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
